gate_pattern_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 18 +
 rtl/gate_pattern_checker_sat_counter.sv | 23 ++
 rtl/gate_pattern_checker.sv | 117 +++++++++++
 tb/tb_gate_pattern_checker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the 2-input gate pattern checker: FSM state
// encoding and truth tables indexed by {b,a}.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a
// synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!clrn || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/gate_pattern_checker.sv
// Drives a 2-input gate through every {b,a} pattern, samples its output
// after a settle time and checks it against the truth table TT.
module gate_pattern_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TT     = TT_NAND,
    parameter int         SETTLE = 2,
    parameter int         PASSES = 1,
    parameter int         ECW    = 8
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           start,
    input  logic           f,
    output logic           a,
    output logic           b,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [ECW-1:0] err_count,
    output logic           fail_valid,
    output logic [1:0]     fail_vec
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int PW = (PASSES < 2) ? 1 : $clog2(PASSES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);
    localparam logic [PW-1:0] PASS_ONE    = PW'(1);

    state_t        state;
    logic [1:0]    p;
    logic [PW-1:0] sweep;
    logic [SW-1:0] settle_cnt;
    logic [1:0]    cur_vec;
    logic          mismatch;
    logic          accept;

    assign cur_vec  = {b, a};
    assign mismatch = (f != TT[cur_vec]);
    assign accept   = (state == ST_IDLE) && start;

    sat_counter #(.WIDTH(ECW)) u_err_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .clear (accept),
        .inc   ((state == ST_CHECK) && mismatch),
        .count (err_count)
    );

    // The pattern index p always equals {b,a}; the sweep count only moves on a 3->0 wrap.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state      <= ST_IDLE;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
            p          <= 2'd0;
            sweep      <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a          <= 1'b0;
                        b          <= 1'b0;
                        p          <= 2'd0;
                        sweep      <= '0;
                        settle_cnt <= '0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 2'b00;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SETTLE_ONE;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= cur_vec;
                    end
                    if ((p == 2'd3) && (sweep == PASS_LAST)) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        p      <= p + 2'd1;
                        {b, a} <= p + 2'd1;
                        if (p == 2'd3) begin
                            sweep <= sweep + PASS_ONE;
                        end
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    pass  <= !fail_valid;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Directed bench: four checker instances, each wired to its own gate model
// (good NAND, stuck-at-1, inverted NAND, good NOR), with a run scoreboard.
module tb_gate_pattern_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [3:0] start_v = 4'b0000;
    wire  [3:0] f_v, a_v, b_v, busy_v, done_v, pass_v, fv_v;
    wire  [1:0] fvec_v [4];
    wire  [7:0] err_v [4];
    wire  [1:0] err_inv;

    int cyc = 0;
    int base = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int         which;
        int         done_cyc;
        logic       pass;
        logic [7:0] err;
        logic       fv;
        logic [1:0] fvec;
        string      tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign f_v[0]   = ~(a_v[0] & b_v[0]);
    assign f_v[1]   = 1'b1;
    assign f_v[2]   = a_v[2] & b_v[2];
    assign f_v[3]   = ~(a_v[3] | b_v[3]);
    assign err_v[2] = {6'd0, err_inv};

    gate_pattern_checker #(.TT(TT_NAND), .SETTLE(2), .PASSES(1), .ECW(8)) u_nand (
        .clk(clk), .clrn(clrn), .start(start_v[0]), .f(f_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .fail_valid(fv_v[0]), .fail_vec(fvec_v[0]));

    gate_pattern_checker #(.TT(TT_NAND), .SETTLE(2), .PASSES(2), .ECW(8)) u_stuck (
        .clk(clk), .clrn(clrn), .start(start_v[1]), .f(f_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .fail_valid(fv_v[1]), .fail_vec(fvec_v[1]));

    gate_pattern_checker #(.TT(TT_NAND), .SETTLE(2), .PASSES(2), .ECW(2)) u_inv (
        .clk(clk), .clrn(clrn), .start(start_v[2]), .f(f_v[2]), .a(a_v[2]), .b(b_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_inv),
        .fail_valid(fv_v[2]), .fail_vec(fvec_v[2]));

    gate_pattern_checker #(.TT(TT_NOR), .SETTLE(1), .PASSES(1), .ECW(8)) u_nor (
        .clk(clk), .clrn(clrn), .start(start_v[3]), .f(f_v[3]), .a(a_v[3]), .b(b_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]),
        .fail_valid(fv_v[3]), .fail_vec(fvec_v[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sb_push(input int which, input int done_cyc, input logic ps,
                           input logic [7:0] err, input logic fv, input logic [1:0] fvec,
                           input string tag);
        exp_t e;
        e.which = which; e.done_cyc = done_cyc; e.pass = ps;
        e.err = err; e.fv = fv; e.fvec = fvec; e.tag = tag;
        sb.push_back(e);
    endtask

    // Raise start for the masked instances across one rising edge; base marks cycle 0.
    task automatic apply_stimulus(input logic [3:0] mask, input bit hold);
        @(negedge clk);
        start_v = start_v | mask;
        @(negedge clk);
        if (!hold) start_v = start_v & ~mask;
        base = cyc;
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        while (!done_v[e.which] && ((cyc - base) < e.done_cyc + 10)) @(negedge clk);
        check({e.tag, "_done_cycle"}, cyc - base, e.done_cyc);
        check({e.tag, "_pass"}, pass_v[e.which], e.pass);
        check({e.tag, "_err_count"}, err_v[e.which], e.err);
        check({e.tag, "_fail_valid"}, fv_v[e.which], e.fv);
        check({e.tag, "_fail_vec"}, fvec_v[e.which], e.fvec);
    endtask

    task automatic check_zero(input int w, input string tag);
        check({tag, "_a"}, a_v[w], 0);
        check({tag, "_b"}, b_v[w], 0);
        check({tag, "_busy"}, busy_v[w], 0);
        check({tag, "_done"}, done_v[w], 0);
        check({tag, "_pass"}, pass_v[w], 0);
        check({tag, "_err"}, err_v[w], 0);
        check({tag, "_fail_valid"}, fv_v[w], 0);
        check({tag, "_fail_vec"}, fvec_v[w], 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero(0, "reset_nand");
        check_zero(2, "reset_inv");
        clrn = 1'b1;

        // Good NAND: pattern order as {a,b} is 00,10,01,11, each held 3 cycles.
        $display("[TB] test 1: good NAND");
        sb_push(0, 13, 1'b1, 8'd0, 1'b0, 2'b00, "nand_ok");
        apply_stimulus(4'b0001, 1'b0);
        check("nand_busy_c0", busy_v[0], 1);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kv;
            kv = k[1:0];
            if (k > 0) repeat (3) @(negedge clk);
            check($sformatf("nand_pattern%0d_ab", k), {a_v[0], b_v[0]}, {kv[0], kv[1]});
        end
        check_output();

        // Stuck-at-1 and inverted-output gates over two sweeps, run together.
        $display("[TB] tests 2/3: stuck-at-1 and inverted gates");
        sb_push(1, 25, 1'b0, 8'd2, 1'b1, 2'b11, "stuck1");
        sb_push(2, 25, 1'b0, 8'd3, 1'b1, 2'b00, "inverted_sat");
        apply_stimulus(4'b0110, 1'b0);
        check_output();
        check_output();

        // Reset during the third pattern, then a fresh clean run.
        $display("[TB] test 4: mid-run reset");
        apply_stimulus(4'b0101, 1'b0);
        repeat (6) @(negedge clk);
        check("inv_err_before_reset", err_v[2], 2);
        check("nand_b_third_pattern", b_v[0], 1);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        check_zero(0, "midreset_nand");
        check_zero(2, "midreset_inv");
        sb_push(0, 13, 1'b1, 8'd0, 1'b0, 2'b00, "after_reset");
        apply_stimulus(4'b0001, 1'b0);
        check_output();

        // start while busy and during DONE must not restart or shift done.
        $display("[TB] test 5: start ignored while busy");
        sb_push(0, 13, 1'b1, 8'd0, 1'b0, 2'b00, "start_busy");
        apply_stimulus(4'b0001, 1'b0);
        repeat (3) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        start_v[0] = 1'b1;
        check_output();
        start_v[0] = 1'b0;
        @(negedge clk);
        check("no_restart_busy", busy_v[0], 0);

        // start held high: back-to-back runs with one IDLE cycle between them.
        sb_push(0, 13, 1'b1, 8'd0, 1'b0, 2'b00, "held_run1");
        sb_push(0, 27, 1'b1, 8'd0, 1'b0, 2'b00, "held_run2");
        apply_stimulus(4'b0001, 1'b1);
        check_output();
        check("held_idle_gap_busy", busy_v[0], 0);
        @(negedge clk);
        check("held_second_run_busy", busy_v[0], 1);
        check_output();
        start_v[0] = 1'b0;
        @(negedge clk);
        check("held_stop_busy", busy_v[0], 0);

        // Good NOR with SETTLE=1.
        $display("[TB] test 6: good NOR, SETTLE=1");
        sb_push(3, 9, 1'b1, 8'd0, 1'b0, 2'b00, "nor_ok");
        apply_stimulus(4'b1000, 1'b0);
        check_output();
        @(negedge clk);
        check("nor_done_single_cycle", done_v[3], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
